// File: rtl/multi_paddle_ctrl.sv
// multi_paddle_ctrl
//   Moves up to four vertical paddles from PS/2 keyboard scan codes.
//   A prefix decoder (F0 = break, E0 = extended) turns the scan-code stream
//   into make/break events that set/clear per-player "up"/"down" held bits.
//   A free-running tick counter moves each paddle one step per tick in the
//   held direction, clamped to [TOP_POS, BOTTOM_POS].
//
// Ports
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   code    in   [7:0] scan-code byte
//   valid   in   one-cycle strobe qualifying code
//   enable  in   motion enable (low freezes tick counter and positions)
//   center  in   one-cycle request: all paddles to START_POS, counter cleared
//   pos     out  [NUM_PLAYERS*POS_W-1:0] paddle top positions, player i at
//                [POS_W*i +: POS_W]
//   held    out  [2*NUM_PLAYERS-1:0] bit 2i = up held, bit 2i+1 = down held
//   tick    out  one-cycle pulse on each motion tick
module multi_paddle_ctrl #(
  parameter int NUM_PLAYERS   = 2,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_LENGTH = 40,
  parameter int FRAME_WIDTH   = 10,
  parameter int MOTION_STEP   = 10,
  parameter int TICK_COUNT    = 1000,
  parameter logic [8*NUM_PLAYERS-1:0] UP_CODES   = {8'h44, 8'h1D},
  parameter logic [8*NUM_PLAYERS-1:0] DOWN_CODES = {8'h4B, 8'h1B},
  localparam int TOP_POS    = FRAME_WIDTH,
  localparam int BOTTOM_POS = SCREEN_HEIGHT - (PADDLE_LENGTH + FRAME_WIDTH),
  localparam int START_POS  = (SCREEN_HEIGHT - PADDLE_LENGTH) / 2,
  localparam int POS_W      = $clog2(BOTTOM_POS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   code,
  input  logic                         valid,
  input  logic                         enable,
  input  logic                         center,
  output logic [NUM_PLAYERS*POS_W-1:0] pos,
  output logic [2*NUM_PLAYERS-1:0]     held,
  output logic                         tick
);

  localparam int PW1 = POS_W + 1;
  localparam int CW  = $clog2(TICK_COUNT);

  localparam logic [CW-1:0]    TICK_LAST = CW'(TICK_COUNT - 1);
  localparam logic [POS_W-1:0] TOP_P     = POS_W'(TOP_POS);
  localparam logic [POS_W-1:0] BOT_P     = POS_W'(BOTTOM_POS);
  localparam logic [POS_W-1:0] START_P   = POS_W'(START_POS);
  localparam logic [PW1-1:0]   UP_LIM_E  = PW1'(TOP_POS + MOTION_STEP);
  localparam logic [PW1-1:0]   STEP_E    = PW1'(MOTION_STEP);
  localparam logic [PW1-1:0]   BOT_E     = PW1'(BOTTOM_POS);

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  dec_state_t state, state_nx;
  logic       make_ev, brk_ev;

  logic [CW-1:0]             cnt;
  logic [2*NUM_PLAYERS-1:0]  held_r;
  logic [POS_W-1:0]          pos_r  [NUM_PLAYERS];
  logic [POS_W-1:0]          pos_mv [NUM_PLAYERS];
  logic                      tick_w;

  // ---------------------------------------------------------------------------
  // Scan-code prefix decoder
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    make_ev  = 1'b0;
    brk_ev   = 1'b0;
    if (valid) begin
      unique case (state)
        IDLE: begin
          if (code == BRK_CODE)      state_nx = BRK;
          else if (code == EXT_CODE) state_nx = EXT;
          else                       make_ev  = 1'b1;
        end
        BRK: begin
          if (code == BRK_CODE)      state_nx = BRK;
          else if (code == EXT_CODE) state_nx = EXT_BRK;
          else begin
            brk_ev   = 1'b1;
            state_nx = IDLE;
          end
        end
        EXT: begin
          // Extended keys are not mapped to paddles: the byte is dropped.
          if (code == BRK_CODE)      state_nx = EXT_BRK;
          else if (code == EXT_CODE) state_nx = EXT;
          else                       state_nx = IDLE;
        end
        EXT_BRK: begin
          if (code != BRK_CODE && code != EXT_CODE) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Held key bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      held_r <= '0;
    end else if (make_ev || brk_ev) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (code == UP_CODES[8*i +: 8])   held_r[2*i]   <= make_ev;
        if (code == DOWN_CODES[8*i +: 8]) held_r[2*i+1] <= make_ev;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Motion tick
  // ---------------------------------------------------------------------------
  assign tick_w = !rst && enable && (cnt == TICK_LAST);

  // Candidate positions for a tick, from the held bits registered before it;
  // widened by one bit so the clamps never wrap.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      pos_mv[i] = pos_r[i];
      if (held_r[2*i] && !held_r[2*i+1]) begin
        if ({1'b0, pos_r[i]} < UP_LIM_E) pos_mv[i] = TOP_P;
        else                             pos_mv[i] = POS_W'({1'b0, pos_r[i]} - STEP_E);
      end else if (held_r[2*i+1] && !held_r[2*i]) begin
        if (({1'b0, pos_r[i]} + STEP_E) > BOT_E) pos_mv[i] = BOT_P;
        else                                     pos_mv[i] = POS_W'({1'b0, pos_r[i]} + STEP_E);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) pos_r[i] <= START_P;
    end else if (center) begin
      cnt <= '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) pos_r[i] <= START_P;
    end else if (enable) begin
      cnt <= (cnt == TICK_LAST) ? '0 : cnt + 1'b1;
      if (tick_w) begin
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) pos_r[i] <= pos_mv[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) pos[POS_W*i +: POS_W] = pos_r[i];
  end

  assign held = held_r;
  assign tick = tick_w;

endmodule

// File: tb/tb_multi_paddle_ctrl.sv
// tb_multi_paddle_ctrl
//   Directed scenarios followed by randomized scan-code traffic, all checked
//   every cycle against a behavioural model of the paddle controller.
module tb_multi_paddle_ctrl;

  localparam int NP     = 2;
  localparam int TC     = 4;
  localparam int PW     = 9;
  localparam int TOP    = 10;
  localparam int BOTTOM = 430;
  localparam int START  = 220;
  localparam int STEP   = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      code = '0;
  logic            valid = 1'b0;
  logic            enable = 1'b0;
  logic            center = 1'b0;
  logic [NP*PW-1:0] pos;
  logic [2*NP-1:0] held;
  logic            tick;

  multi_paddle_ctrl #(.TICK_COUNT(TC)) dut (
    .clk    (clk),
    .rst    (rst),
    .code   (code),
    .valid  (valid),
    .enable (enable),
    .center (center),
    .pos    (pos),
    .held   (held),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] up_c [NP] = '{8'h1D, 8'h44};
  logic [7:0] dn_c [NP] = '{8'h1B, 8'h4B};

  int         m_cnt;
  int         m_pos [NP];
  logic [3:0] m_held;
  bit         m_ext, m_brk;
  int         m_ticks;

  function automatic void model(bit r, bit v, logic [7:0] c, bit ctr);
    bit t;
    if (r) begin
      m_cnt = 0; m_held = '0; m_ext = 0; m_brk = 0;
      for (int p = 0; p < NP; p++) m_pos[p] = START;
      return;
    end
    t = enable && (m_cnt == TC - 1);
    if (ctr) begin
      for (int p = 0; p < NP; p++) m_pos[p] = START;
      m_cnt = 0;
    end else if (enable) begin
      if (t) begin
        m_ticks++;
        for (int p = 0; p < NP; p++) begin
          if (m_held[2*p] && !m_held[2*p+1])
            m_pos[p] = (m_pos[p] - STEP < TOP) ? TOP : m_pos[p] - STEP;
          else if (m_held[2*p+1] && !m_held[2*p])
            m_pos[p] = (m_pos[p] + STEP > BOTTOM) ? BOTTOM : m_pos[p] + STEP;
        end
      end
      m_cnt = (m_cnt + 1) % TC;
    end
    if (v) begin
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hE0) m_ext = 1;
      else begin
        if (!m_ext) begin
          for (int p = 0; p < NP; p++) begin
            if (c == up_c[p]) m_held[2*p]   = !m_brk;
            if (c == dn_c[p]) m_held[2*p+1] = !m_brk;
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit r, input bit v, input logic [7:0] c, input bit ctr);
    rst = r; valid = v; code = c; center = ctr;
    model(r, v, c, ctr);
    @(posedge clk); #1;
    rst = 0; valid = 0; center = 0;
    for (int p = 0; p < NP; p++) check("pos", int'(pos[PW*p +: PW]), m_pos[p]);
    check("held", int'(held), int'(m_held));
    check("tick", int'(tick), int'(enable && (m_cnt == TC - 1)));
  endtask

  task automatic key(input logic [7:0] c);
    step(0, 1, c, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 8'h00, 0);
  endtask

  task automatic ticks(input int n);
    int target, budget;
    target = m_ticks + n;
    budget = n * TC + TC;
    while (m_ticks < target && budget > 0) begin
      step(0, 0, 8'h00, 0);
      budget--;
    end
    if (m_ticks < target) check("tick_timeout", m_ticks, target);
  endtask

  function automatic logic [7:0] rnd_code();
    logic [7:0] pool [7] = '{8'h1D, 8'h1B, 8'h44, 8'h4B, 8'hF0, 8'hE0, 8'h00};
    int k;
    k = $urandom_range(0, 6);
    if (k == 6) return 8'($urandom);
    return pool[k];
  endfunction

  initial begin
    m_ticks = 0;
    // Reset state
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h1D, 1);
    check("rst_pos0", int'(pos[PW-1:0]), START);
    check("rst_pos1", int'(pos[2*PW-1:PW]), START);
    check("rst_held", int'(held), 0);
    check("rst_tick", int'(tick), 0);

    // Basic up motion
    enable = 1;
    key(8'h1D);
    check("make_1D", int'(held), 1);
    ticks(1);
    check("pos0_first", int'(pos[PW-1:0]), 210);
    ticks(4);
    check("pos0_after5", int'(pos[PW-1:0]), 170);
    check("pos1_still", int'(pos[2*PW-1:PW]), START);

    // Break stops motion
    key(8'hF0); key(8'h1D);
    check("break_1D", int'(held), 0);
    ticks(2);
    check("pos0_stopped", int'(pos[PW-1:0]), 170);

    // Saturation at bottom and top
    key(8'h1B);
    ticks(30);
    check("pos0_bottom", int'(pos[PW-1:0]), BOTTOM);
    key(8'hF0); key(8'h1B); key(8'h1D);
    ticks(50);
    check("pos0_top", int'(pos[PW-1:0]), TOP);
    key(8'hF0); key(8'h1D);

    // Extended-prefixed bytes are ignored
    key(8'hE0); key(8'h1D); key(8'hE0); key(8'hF0); key(8'h1D);
    check("ext_held", int'(held), 0);
    ticks(2);
    check("ext_nomove", int'(pos[PW-1:0]), TOP);
    key(8'h1D);
    check("ext_back_idle", int'(held), 1);
    key(8'hF0); key(8'h1D);

    // Center coincident with tick
    for (int k = 0; k < TC && m_cnt != TC - 1; k++) idle(1);
    check("pre_center_phase", int'(tick), 1);
    step(0, 0, 8'h00, 1);
    check("center_pos0", int'(pos[PW-1:0]), START);
    idle(TC - 2);
    check("center_cnt_notick", int'(tick), 0);
    idle(1);
    check("center_cnt_tick", int'(tick), 1);

    // Both directions held: no motion
    key(8'h1D); key(8'h1B);
    check("both_held", int'(held), 3);
    ticks(3);
    check("both_nomove", int'(pos[PW-1:0]), START);
    key(8'hF0); key(8'h1D); key(8'hF0); key(8'h1B);

    // Enable low freezes everything
    key(8'h44);
    enable = 0;
    for (int k = 0; k < 3 * TC; k++) begin
      idle(1);
      check("frozen_tick", int'(tick), 0);
    end
    check("frozen_pos1", int'(pos[2*PW-1:PW]), START);
    enable = 1;
    ticks(1);
    check("pos1_moves", int'(pos[2*PW-1:PW]), START - STEP);
    key(8'hF0); key(8'h44);

    // Reset discards a pending break prefix
    key(8'hF0);
    step(1, 0, 8'h00, 0);
    key(8'h1D);
    check("rst_prefix", int'(held), 1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
           rnd_code(), ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_paddle_ctrl.md
MULTI_PADDLE_CTRL -- requirements
Module: multi_paddle_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of paddles (1..4).
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480, screen height in pixels.
REQ-003 SHALL have parameter PADDLE_LENGTH, default 40, paddle length in pixels.
REQ-004 SHALL have parameter FRAME_WIDTH, default 10, border size; top limit TOP_POS = FRAME_WIDTH.
REQ-005 SHALL have parameter MOTION_STEP, default 10, pixels moved per tick.
REQ-006 SHALL have parameter TICK_COUNT, default 1000, clk cycles per motion tick (>= 2).
REQ-007 SHALL have parameter UP_CODES, default {8'h44, 8'h1D}, packed 8*NUM_PLAYERS make codes; player i uses bits [8i+7:8i].
REQ-008 SHALL have parameter DOWN_CODES, default {8'h4B, 8'h1B}, same packing as UP_CODES.
REQ-009 SHALL derive BOTTOM_POS = SCREEN_HEIGHT-(PADDLE_LENGTH+FRAME_WIDTH), START_POS = (SCREEN_HEIGHT-PADDLE_LENGTH)/2, POS_W = $clog2(BOTTOM_POS+1).
REQ-010 clk  in  1  system clock, 50 MHz; single clock domain.
REQ-011 rst  in  1  reset, synchronous, active-high.
REQ-012 code  in  8  scan-code byte from the PS/2 receiver.
REQ-013 valid  in  1  one-cycle strobe qualifying code.
REQ-014 enable  in  1  motion enable; low freezes tick counter and positions.
REQ-015 center  in  1  one-cycle request to return all paddles to START_POS.
REQ-016 pos  out  NUM_PLAYERS*POS_W  paddle top positions; player i at [POS_W*i+POS_W-1:POS_W*i].
REQ-017 held  out  2*NUM_PLAYERS  key state; bit 2i = up held, bit 2i+1 = down held for player i.
REQ-018 tick  out  1  one-cycle pulse on each motion tick.

Function
REQ-019 Decoder FSM SHALL have states IDLE, BRK, EXT, EXT_BRK, advancing only on valid.
REQ-020 IDLE: F0 -> BRK; E0 -> EXT; any other code -> make event for that code, stay IDLE.
REQ-021 BRK: F0 -> BRK; E0 -> EXT_BRK; other -> break event for that code, -> IDLE.
REQ-022 EXT: F0 -> EXT_BRK; E0 -> EXT; other -> discarded (no key change), -> IDLE.
REQ-023 EXT_BRK: F0 or E0 -> EXT_BRK; other -> discarded, -> IDLE.
REQ-024 Make event SHALL set every held bit whose mapped code equals the byte; break event SHALL clear them; unmapped codes no effect; held visible the cycle after valid.
REQ-025 Tick counter SHALL count 0..TICK_COUNT-1 while enable=1, wrap to 0, assert tick in the cycle it is TICK_COUNT-1; enable=0 holds counter and tick=0.
REQ-026 On tick, per player, using held as registered before that cycle: up only -> pos = (pos < TOP_POS+MOTION_STEP) ? TOP_POS : pos-MOTION_STEP; down only -> pos = (pos+MOTION_STEP > BOTTOM_POS) ? BOTTOM_POS : pos+MOTION_STEP; both or neither -> unchanged.
REQ-027 Clamp arithmetic SHALL use POS_W+1 bits; no wrap-around under any parameter set.
REQ-028 center SHALL set all pos to START_POS and clear the tick counter; center has priority over a coincident tick; held unaffected.
REQ-029 A valid coincident with tick SHALL update held normally; that tick uses the old held.
REQ-030 Players SHALL move independently within the same tick.

Reset
REQ-031 rst SHALL put FSM in IDLE, counter 0, tick 0, held all 0, every pos = START_POS (220 at defaults); rst overrides valid, center and enable.
REQ-032 rst mid-sequence (e.g. after F0) SHALL discard the pending prefix.

Verification (defaults except TICK_COUNT=4)
REQ-033 After rst, enable=1, valid with 1D -> held[0]=1; next tick pos0 = 210; after 4 more ticks pos0 = 170; pos1 stays 220.
REQ-034 Hold 1B for 30 ticks -> pos0 saturates at 430, then stays 430; hold 1D from there for 50 ticks -> pos0 saturates at 10.
REQ-035 Sequence 1D, then F0, 1D -> held[0] 1 then 0; pos0 stops changing on the tick after the break.
REQ-036 Sequence E0, 1D, then E0, F0, 1D -> held stays 0, FSM back in IDLE, no motion.
REQ-037 Hold 1D and 1B together -> pos0 unchanged; enable=0 with 44 held -> tick stays 0 and pos1 frozen.
REQ-038 With pos0 = 10, assert center coincident with tick -> pos0 = 220, counter 0; rst after lone F0 then code 1D -> make event (held[0]=1).
